// File: rtl/ara_pkg.sv
// Shared vector-unit types plus the VRF byte-shuffle mapping used by the mask write paths.
`default_nettype none

package ara_pkg;

  localparam int unsigned ELEN = 64;

  typedef logic [ELEN-1:0]   elen_t;
  typedef logic [ELEN/8-1:0] strb_t;

  typedef enum logic [1:0] {
    EW8  = 2'b00,
    EW16 = 2'b01,
    EW32 = 2'b10,
    EW64 = 2'b11
  } vew_e;

  typedef enum logic {
    OB_IDLE  = 1'b0,
    OB_DRAIN = 1'b1
  } masku_ob_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Elements are dealt round-robin over the lanes; within a lane they stack upward.
  function automatic int unsigned shuffle_index(input int unsigned byte_index,
                                                input int unsigned nr_lanes,
                                                input vew_e        ew);
    int unsigned ebytes;
    int unsigned el;
    int unsigned lane;
    ebytes = 32'd1 << ew;
    el     = byte_index / ebytes;
    lane   = el % nr_lanes;
    return lane * (ELEN / 8) + (el / nr_lanes) * ebytes + (byte_index % ebytes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/masku_shuffle_word.sv
// Combinational reshuffle of a sequential datapath word into per-lane VRF words and byte strobes.
`default_nettype none

module masku_shuffle_word import ara_pkg::*; #(
  parameter int unsigned NrLanes = 4,
  localparam int unsigned NrBytes = NrLanes * ELEN / 8,
  localparam int unsigned ByteCntWidth = $clog2(NrBytes) + 1
) (
  input  logic [NrLanes*ELEN-1:0] seq_i,
  input  logic [ByteCntWidth-1:0] nbytes_i,
  input  vew_e                    eew_i,
  output elen_t [NrLanes-1:0]     data_o,
  output strb_t [NrLanes-1:0]     be_o
);

  logic [NrLanes*ELEN-1:0] shuf_data;
  logic [NrBytes-1:0]      shuf_be;

  // Loop over every encoding so each shuffle_index call sees constant arguments.
  always_comb begin
    shuf_data = '0;
    shuf_be   = '0;
    for (int e = 0; e < 4; e++) begin
      if (eew_i == vew_e'(e)) begin
        for (int s = 0; s < int'(NrBytes); s++) begin
          shuf_data[shuffle_index(s, NrLanes, vew_e'(e))*8 +: 8] = seq_i[s*8 +: 8];
          shuf_be[shuffle_index(s, NrLanes, vew_e'(e))]          = (ByteCntWidth'(s) < nbytes_i);
        end
      end
    end
  end

  assign data_o = shuf_data;
  assign be_o   = shuf_be;

endmodule

`default_nettype wire

// File: rtl/masku_result_packer.sv
// Mask-unit write-back: packs sequential mask-bit chunks into datapath words and drains them,
// reshuffled for the destination EEW, to the lanes with independent per-lane handshakes.
`default_nettype none

module masku_result_packer import ara_pkg::*; #(
  parameter int unsigned NrLanes = 4,
  localparam int unsigned DataWidth = NrLanes * ELEN,
  localparam int unsigned CntWidth  = idx_width(DataWidth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_bits_i,
  input  logic [CntWidth-1:0]  in_cnt_i,
  input  logic                 in_last_i,
  input  vew_e                 eew_i,
  output logic [NrLanes-1:0]   out_valid_o,
  input  logic [NrLanes-1:0]   out_ready_i,
  output elen_t [NrLanes-1:0]  out_data_o,
  output strb_t [NrLanes-1:0]  out_be_o,
  output logic                 busy_o
);

  localparam int unsigned StrbWidth    = ELEN / 8;
  localparam int unsigned NrBytes      = NrLanes * StrbWidth;
  localparam int unsigned ByteCntWidth = $clog2(NrBytes) + 1;

  typedef logic [CntWidth-1:0] cnt_t;

  function automatic logic [DataWidth-1:0] low_mask(input logic [CntWidth:0] n);
    logic [DataWidth-1:0] m;
    for (int i = 0; i < int'(DataWidth); i++) m[i] = ((CntWidth+1)'(i) < n);
    return m;
  endfunction

  function automatic logic [ByteCntWidth-1:0] bytes_of(input cnt_t nbits);
    logic [CntWidth:0] t;
    t = {1'b0, nbits} + (CntWidth+1)'(7);
    return ByteCntWidth'(t >> 3);
  endfunction

  // Accumulator state
  logic [DataWidth-1:0] acc_q, acc_d;
  cnt_t                 fill_q, fill_d;
  logic                 pend_q, pend_d;
  vew_e                 eew_q, eew_d;

  // Output buffer state
  masku_ob_state_e      ob_state_q, ob_state_d;
  logic [NrLanes-1:0]   valid_q, valid_d;
  elen_t [NrLanes-1:0]  data_q, data_d;
  strb_t [NrLanes-1:0]  be_q, be_d;

  logic [CntWidth:0]      sum;
  cnt_t                   rem;
  logic [DataWidth-1:0]   bits_m;
  logic [DataWidth-1:0]   fill_mask;
  logic [2*DataWidth-1:0] wide;
  logic                   full, completes, accept;
  logic                   drain_done, ob_free, load_pend, load_in;

  logic [DataWidth-1:0]    sh_word;
  logic [ByteCntWidth-1:0] sh_bytes;
  vew_e                    sh_eew;
  elen_t [NrLanes-1:0]     sh_data;
  strb_t [NrLanes-1:0]     sh_be;

  assign bits_m    = in_bits_i & low_mask({1'b0, in_cnt_i});
  assign fill_mask = low_mask({1'b0, fill_q});
  assign sum       = {1'b0, fill_q} + {1'b0, in_cnt_i};
  assign full      = (sum >= (CntWidth+1)'(DataWidth));
  assign rem       = cnt_t'(sum - (CntWidth+1)'(DataWidth));
  assign completes = full || (in_last_i && (sum != '0));

  // Low half is the (zero-padded) completed word, high half the overflow remainder at bit 0.
  assign wide = {{DataWidth{1'b0}}, acc_q & fill_mask}
              | ({{DataWidth{1'b0}}, bits_m} << fill_q);

  assign drain_done = (ob_state_q == OB_DRAIN) && ((valid_q & ~out_ready_i) == '0);
  assign ob_free    = (ob_state_q == OB_IDLE) || drain_done;
  assign in_ready_o = !pend_q && (!completes || ob_free);
  assign accept     = in_valid_i && in_ready_o;
  assign load_pend  = pend_q && ob_free;
  assign load_in    = accept && completes;

  always_comb begin
    sh_word  = wide[DataWidth-1:0];
    sh_bytes = full ? ByteCntWidth'(NrBytes) : bytes_of(sum[CntWidth-1:0]);
    sh_eew   = eew_i;
    if (pend_q) begin
      sh_word  = acc_q & fill_mask;
      sh_bytes = bytes_of(fill_q);
      sh_eew   = eew_q;
    end
  end

  masku_shuffle_word #(
    .NrLanes (NrLanes)
  ) i_shuffle (
    .seq_i    (sh_word),
    .nbytes_i (sh_bytes),
    .eew_i    (sh_eew),
    .data_o   (sh_data),
    .be_o     (sh_be)
  );

  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    pend_d = pend_q;
    eew_d  = eew_q;
    if (load_pend) begin
      fill_d = '0;
      pend_d = 1'b0;
    end
    if (accept) begin
      eew_d = eew_i;
      if (full) begin
        acc_d  = (acc_q & ~low_mask({1'b0, rem})) | wide[2*DataWidth-1:DataWidth];
        fill_d = rem;
        pend_d = in_last_i && (rem != '0);
      end else if (in_last_i) begin
        fill_d = '0;
      end else begin
        acc_d  = (acc_q & ~(low_mask({1'b0, in_cnt_i}) << fill_q)) | (bits_m << fill_q);
        fill_d = sum[CntWidth-1:0];
      end
    end
  end

  always_comb begin
    ob_state_d = ob_state_q;
    valid_d    = valid_q & ~out_ready_i;
    data_d     = data_q;
    be_d       = be_q;
    if (load_pend || load_in) begin
      ob_state_d = OB_DRAIN;
      valid_d    = '1;
      data_d     = sh_data;
      be_d       = sh_be;
    end else if (drain_done) begin
      ob_state_d = OB_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q      <= '0;
      fill_q     <= '0;
      pend_q     <= 1'b0;
      eew_q      <= EW8;
      ob_state_q <= OB_IDLE;
      valid_q    <= '0;
      data_q     <= '0;
      be_q       <= '0;
    end else if (flush_i) begin
      acc_q      <= '0;
      fill_q     <= '0;
      pend_q     <= 1'b0;
      eew_q      <= EW8;
      ob_state_q <= OB_IDLE;
      valid_q    <= '0;
      data_q     <= '0;
      be_q       <= '0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      pend_q     <= pend_d;
      eew_q      <= eew_d;
      ob_state_q <= ob_state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      be_q       <= be_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_be_o    = be_q;
  assign busy_o      = (fill_q != '0) || pend_q || (ob_state_q != OB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_masku_result_packer.sv
// Self-checking bench for masku_result_packer: directed tables/sequences plus randomized traffic
// against a bit-queue reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_masku_result_packer;
  import ara_pkg::*;

  localparam int unsigned NrLanes = 4;
  localparam int unsigned W       = NrLanes * ELEN;
  localparam int unsigned CW      = $clog2(W) + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W-1:0]        in_bits = '0;
  logic [CW-1:0]       in_cnt = '0;
  logic                in_last = 1'b0;
  vew_e                eew = EW8;
  logic [NrLanes-1:0]  out_valid;
  logic [NrLanes-1:0]  out_ready = '1;
  elen_t [NrLanes-1:0] out_data;
  strb_t [NrLanes-1:0] out_be;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit rnd_ready = 1'b0;

  always #5 clk = ~clk;

  masku_result_packer #(.NrLanes(NrLanes)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_bits_i   (in_bits),
    .in_cnt_i    (in_cnt),
    .in_last_i   (in_last),
    .eew_i       (eew),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_be_o    (out_be),
    .busy_o      (busy)
  );

  // Reference model: a plain FIFO of bits, cut into words of W bits or flushed by "last".
  typedef struct { logic [W-1:0] word; int nbits; vew_e ew; } exp_t;
  exp_t               expq[$];
  bit                 mq[$];
  logic [NrLanes-1:0] lane_done = '0;

  typedef struct {
    int              cnt;
    logic [63:0]     bits;
    vew_e            ew;
    logic [3:0][63:0] d;
    logic [3:0][7:0]  be;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_lane(input exp_t e, input int lane, output elen_t d, output strb_t b);
    int eb, el, off;
    eb = 1 << int'(e.ew);
    d = '0;
    b = '0;
    for (int s = 0; s < int'(W/8); s++) begin
      el = s / eb;
      if (el % NrLanes == lane) begin
        off = (el / NrLanes) * eb + s % eb;
        d[off*8 +: 8] = e.word[s*8 +: 8];
        b[off] = (s * 8 < e.nbits);
      end
    end
  endtask

  task automatic push_word(input int n);
    exp_t e;
    e.word = '0;
    for (int i = 0; i < n; i++) e.word[i] = mq.pop_front();
    e.nbits = n;
    e.ew = eew;
    expq.push_back(e);
  endtask

  task automatic mon_step();
    elen_t d;
    strb_t b;
    if (!rst_n || flush) begin
      expq.delete();
      mq.delete();
      lane_done = '0;
      return;
    end
    for (int l = 0; l < int'(NrLanes); l++) begin
      if (out_valid[l] && out_ready[l]) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: lane %0d got data %0h, no word expected", l, out_data[l]);
        end else begin
          exp_lane(expq[0], l, d, b);
          chk($sformatf("sb_data_l%0d", l), W'(out_data[l]), W'(d));
          chk($sformatf("sb_be_l%0d", l), W'(out_be[l]), W'(b));
          lane_done[l] = 1'b1;
        end
      end
    end
    if (lane_done == '1) begin
      void'(expq.pop_front());
      lane_done = '0;
    end
    if (in_valid && in_ready) begin
      for (int i = 0; i < int'(in_cnt); i++) mq.push_back(in_bits[i]);
      if (mq.size() >= W) push_word(W);
      if (in_last && mq.size() > 0) push_word(mq.size());
    end
  endtask

  task automatic send(input int cnt, input logic [W-1:0] bits, input logic last, input vew_e ew);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_cnt   = CW'(cnt);
    in_bits  = bits;
    in_last  = last;
    eew      = ew;
    if (rnd_ready) out_ready = NrLanes'($urandom);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      if (rnd_ready) out_ready = NrLanes'($urandom);
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready_o got 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    out_ready = '1;
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (!busy && expq.size() == 0) ok = 1'b1;
    end
    chk("idle_reached", W'(ok), W'(1));
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < int'(W/32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    logic [W-1:0]        ramp;
    elen_t               ed;
    int                  cyc[4];
    logic [NrLanes-1:0]  ev;
    vew_e                rew;
    int                  rc;

    vecs[0] = '{12, 64'hABC, EW64, {64'h0, 64'h0, 64'h0, 64'hABC}, {8'h0, 8'h0, 8'h0, 8'h03}};
    vecs[1] = '{8, 64'hA5, EW8, {64'h0, 64'h0, 64'h0, 64'hA5}, {8'h0, 8'h0, 8'h0, 8'h01}};
    vecs[2] = '{16, 64'hBEEF, EW8, {64'h0, 64'h0, 64'hBE, 64'hEF}, {8'h0, 8'h0, 8'h01, 8'h01}};
    vecs[3] = '{64, 64'h1122334455667788, EW32, {64'h0, 64'h0, 64'h11223344, 64'h55667788},
                {8'h0, 8'h0, 8'h0F, 8'h0F}};
    vecs[4] = '{1, 64'hFFFFFFFF, EW16, {64'h0, 64'h0, 64'h0, 64'h1}, {8'h0, 8'h0, 8'h0, 8'h01}};
    vecs[5] = '{20, 64'hFFFFFFFF, EW16, {64'h0, 64'h0, 64'h0F, 64'hFFFF}, {8'h0, 8'h0, 8'h01, 8'h03}};
    vecs[6] = '{40, 64'hFFFF_FFCC_DDEE_FF11, EW8, {64'hDD, 64'hEE, 64'hFF, 64'hCC11},
                {8'h01, 8'h01, 8'h01, 8'h03}};

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_data", W'(out_data), W'(0));
    chk("rst_be", W'(out_be), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Four EW64 chunks, one word
    out_ready = '1;
    send(64, W'({16{4'h1}}), 1'b0, EW64);
    send(64, W'({16{4'h2}}), 1'b0, EW64);
    send(64, W'({16{4'h3}}), 1'b0, EW64);
    @(negedge clk);
    chk("t1_no_early_valid", W'(out_valid), W'(0));
    chk("t1_busy_filling", W'(busy), W'(1));
    send(64, W'({16{4'h4}}), 1'b1, EW64);
    @(negedge clk);
    chk("t1_valid", W'(out_valid), W'(4'hF));
    for (int k = 0; k < 4; k++) begin
      ed = {16{4'(k + 1)}};
      chk($sformatf("t1_data_l%0d", k), W'(out_data[k]), W'(ed));
      chk($sformatf("t1_be_l%0d", k), W'(out_be[k]), W'(8'hFF));
    end
    wait_idle();

    // Single-chunk last words across EEWs
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].cnt, W'(vecs[i].bits), 1'b1, vecs[i].ew);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), W'(out_valid), W'(4'hF));
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("vec%0d_d%0d", i, l), W'(out_data[l]), W'(vecs[i].d[l]));
        chk($sformatf("vec%0d_be%0d", i, l), W'(out_be[l]), W'(vecs[i].be[l]));
      end
      wait_idle();
    end

    // Staggered lane readies with a completing chunk waiting
    cyc = '{2, 5, 3, 7};
    @(posedge clk); #1;
    out_ready = '0;
    in_valid  = 1'b1;
    in_cnt    = CW'(W);
    in_bits   = rand_word();
    in_last   = 1'b0;
    eew       = EW64;
    @(negedge clk);
    chk("t3_ready_idle", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_bits = rand_word();
    for (int c = 1; c <= 8; c++) begin
      for (int l = 0; l < 4; l++) out_ready[l] = (c == cyc[l]);
      if (c == 8) in_valid = 1'b0;
      @(negedge clk);
      if (c <= 7) begin
        for (int l = 0; l < 4; l++) ev[l] = (c <= cyc[l]);
        chk($sformatf("t3_in_ready_c%0d", c), W'(in_ready), W'(c == 7));
        chk($sformatf("t3_valid_c%0d", c), W'(out_valid), W'(ev));
      end else begin
        chk("t3_no_bubble", W'(out_valid), W'(4'hF));
      end
      @(posedge clk); #1;
    end
    wait_idle();

    // Overflowing last chunk -> two words
    send(200, rand_word(), 1'b0, EW64);
    send(100, rand_word(), 1'b1, EW64);
    @(negedge clk);
    chk("t4_word1_valid", W'(out_valid), W'(4'hF));
    chk("t4_in_ready_held", W'(in_ready), W'(0));
    chk("t4_word1_be", W'(out_be), W'({4{8'hFF}}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_word2_valid", W'(out_valid), W'(4'hF));
    chk("t4_word2_be", W'(out_be), W'({8'h00, 8'h00, 8'h00, 8'h3F}));
    chk("t4_in_ready_free", W'(in_ready), W'(1));
    wait_idle();

    // EW8 byte ramp
    for (int i = 0; i < int'(W/8); i++) ramp[i*8 +: 8] = 8'(i);
    send(W, ramp, 1'b1, EW8);
    @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      for (int o = 0; o < 8; o++) ed[o*8 +: 8] = 8'(o * 4 + l);
      chk($sformatf("t5_ramp_l%0d", l), W'(out_data[l]), W'(ed));
    end
    wait_idle();

    // Asynchronous reset mid-drain with two lanes outstanding and a partial accumulator
    out_ready = '0;
    send(W, rand_word(), 1'b0, EW32);
    send(10, rand_word(), 1'b0, EW32);
    out_ready = 4'b0011;
    @(posedge clk); #1;
    out_ready = '0;
    @(negedge clk);
    chk("t6_outstanding", W'(out_valid), W'(4'b1100));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_clear", W'(out_valid), W'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy_after", W'(busy), W'(0));
    out_ready = '1;
    send(8, W'(64'h5A), 1'b1, EW8);
    @(negedge clk);
    chk("t6_fill_cleared_d", W'(out_data[0]), W'(64'h5A));
    chk("t6_fill_cleared_be", W'(out_be), W'(32'h0000_0001));
    wait_idle();

    // Flush mid-drain
    out_ready = '0;
    send(W, rand_word(), 1'b0, EW16);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t7_flush_valid", W'(out_valid), W'(0));
    chk("t7_flush_busy", W'(busy), W'(0));
    wait_idle();

    // Randomized traffic against the model
    rnd_ready = 1'b1;
    rew = vew_e'($urandom_range(0, 3));
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       rc = 0;
        1:       rc = W;
        2:       rc = 64;
        default: rc = $urandom_range(1, W);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        send(rc, rand_word(), 1'b1, rew);
        rew = vew_e'($urandom_range(0, 3));
      end else begin
        send(rc, rand_word(), 1'b0, rew);
      end
    end
    send(0, '0, 1'b1, rew);
    rnd_ready = 1'b0;
    wait_idle();
    chk("sb_empty", W'(expq.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
